reset_sync: RTL and testbench

// - Reset synchronizer: asynchronous assertion, synchronous deassertion of a local reset.
// - Output valid is an active-high "out of reset" qualifier for downstream logic in the clk domain.
// - Sits at the boundary between the board/POR reset and each clocked subsystem.
// - Gate-level netlist is SDF-annotated; the rst_n minimum pulse width is a timing check.

---
 rtl/reset_sync_pkg.sv | 18 +
 rtl/reset_sync_cell.sv | 24 ++
 rtl/reset_sync.sv | 73 +++++++
 tb/tb_reset_sync.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/reset_sync_pkg.sv
`timescale 1ns/1ps
// reset_sync_pkg: shared limits and types for the reset synchronizer.
// Ports: none (package).
// Exports MIN/MAX stage limits, hold-counter type and a saturating increment.
package reset_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;
  localparam int MAX_HOLD   = 255;

  typedef logic [7:0] hold_cnt_t;

  // Increment that stops at lim instead of wrapping.
  function automatic hold_cnt_t sat_inc(input hold_cnt_t cnt, input hold_cnt_t lim);
    return (cnt == lim) ? cnt : cnt + hold_cnt_t'(1);
  endfunction

endpackage

// File: rtl/reset_sync_cell.sv
`timescale 1ns/1ps
// sync_cell: one asynchronously cleared D flop used as a synchronizer stage.
// Ports: clk (clock), rst_n (async active-low clear), d_i (data in), q_o (flop out).
// Kept as its own module so each stage has a stable instance name for placement/SDF.
module sync_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reset_sync.sv
`timescale 1ns/1ps
// reset_sync: async-assert / sync-deassert reset synchronizer with optional hold-off.
// Ports: clk (domain clock), rst_n (async active-low reset in),
//        valid (1 = domain out of reset, registered, 0 immediately on rst_n low).
module reset_sync
  import reset_sync_pkg::*;
#(
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic valid
);

  // Parameter legality, checked at elaboration.
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $fatal(1, "reset_sync: STAGES=%0d outside %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
  end
  if (HOLD_CYCLES < 0 || HOLD_CYCLES > MAX_HOLD) begin : g_bad_hold
    $fatal(1, "reset_sync: HOLD_CYCLES=%0d outside 0..%0d", HOLD_CYCLES, MAX_HOLD);
  end

  localparam hold_cnt_t HOLD = hold_cnt_t'(HOLD_CYCLES);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;
  logic              released_q;
  logic              released_d;
  hold_cnt_t         cnt_q;
  hold_cnt_t         cnt_d;
  logic              valid_q;
  logic              valid_d;

  // A constant 1 enters stage 0; every other stage copies its predecessor.
  assign chain_d = {chain_q[STAGES-2:0], 1'b1};

  for (genvar i = 0; i < STAGES; i++) begin : g_chain
    sync_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (chain_d[i]),
      .q_o   (chain_q[i])
    );
  end

  assign released_q = chain_q[STAGES-1];
  // Value the last stage will hold after this edge; lets valid be registered
  // without adding a cycle of latency beyond the chain itself.
  assign released_d = chain_d[STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (released_q) begin
      cnt_d = sat_inc(cnt_q, HOLD);
    end
    valid_d = released_d && (cnt_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_reset_sync.sv
`timescale 1ns/1ps
// tb_reset_sync: directed and randomized checks of reset_sync in four configurations.
// Ports: none (testbench top).
// Model: valid must equal rst_n && (rising clk edges since rst_n last went high >= STAGES+HOLD_CYCLES).
module tb_reset_sync;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic v_s2;  // STAGES=2 HOLD=0
  logic v_h3;  // STAGES=2 HOLD=3
  logic v_s4;  // STAGES=4 HOLD=0
  logic v_mx;  // STAGES=3 HOLD=5

  int errors = 0;
  int checks = 0;

  // Behavioural model: clk edges seen since the most recent release of rst_n.
  int n_edges = 0;

  reset_sync #(.STAGES(2), .HOLD_CYCLES(0)) u_s2 (.clk(clk), .rst_n(rst_n), .valid(v_s2));
  reset_sync #(.STAGES(2), .HOLD_CYCLES(3)) u_h3 (.clk(clk), .rst_n(rst_n), .valid(v_h3));
  reset_sync #(.STAGES(4), .HOLD_CYCLES(0)) u_s4 (.clk(clk), .rst_n(rst_n), .valid(v_s4));
  reset_sync #(.STAGES(3), .HOLD_CYCLES(5)) u_mx (.clk(clk), .rst_n(rst_n), .valid(v_mx));

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: valid=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic at(input int t);
    #(t - $time);
  endtask

  function automatic logic model_valid(input int latency);
    return (rst_n === 1'b1) && (n_edges >= latency);
  endfunction

  // Model update.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && n_edges < 100000) n_edges = n_edges + 1;
  end
  always @(negedge rst_n) n_edges = 0;

  // Per-cycle comparison against the model, 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    chk("cyc_s2", v_s2, model_valid(2));
    chk("cyc_h3", v_h3, model_valid(5));
    chk("cyc_s4", v_s4, model_valid(4));
    chk("cyc_mx", v_mx, model_valid(8));
  end

  // Assertion must clear valid without any clock edge.
  always begin
    @(negedge rst_n);
    #1;
    chk("async_s2", v_s2, 1'b0);
    chk("async_h3", v_h3, 1'b0);
    chk("async_s4", v_s4, 1'b0);
    chk("async_mx", v_mx, 1'b0);
  end

  initial begin
    int hi;
    int lo;
    int cyc;

    // Power-on release at 10 ns.
    at(10);  rst_n = 1'b1;
    at(24);  chk("pon_s2_before", v_s2, 1'b0);
    at(26);  chk("pon_s2_after", v_s2, 1'b1);
             chk_int("model_edges_pon", n_edges, 2);
             chk("pon_s4_early", v_s4, 1'b0);
    at(44);  chk("pon_s4_before", v_s4, 1'b0);
    at(46);  chk("pon_s4_after", v_s4, 1'b1);
    at(54);  chk("pon_h3_before", v_h3, 1'b0);
    at(56);  chk("pon_h3_after", v_h3, 1'b1);
             chk("pon_mx_early", v_mx, 1'b0);

    // 3 ns glitch restarts the full sequence.
    at(60);  rst_n = 1'b0;
    at(61);  chk("glitch_s2_low", v_s2, 1'b0);
    at(63);  rst_n = 1'b1;
    at(74);  chk("glitch_s2_before", v_s2, 1'b0);
    at(76);  chk("glitch_s2_after", v_s2, 1'b1);
             chk_int("model_edges_glitch", n_edges, 2);

    // Re-assertion while the chain is filling.
    at(90);  rst_n = 1'b0;
    at(100); rst_n = 1'b1;
    at(107); rst_n = 1'b0;
    at(112); rst_n = 1'b1;
    at(114); chk("midfill_s2_first", v_s2, 1'b0);
    at(124); chk("midfill_s2_before", v_s2, 1'b0);
    at(126); chk("midfill_s2_after", v_s2, 1'b1);

    // Long reset: 100 cycles, valid held low (per-cycle checker covers each cycle).
    at(142); rst_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("long_s4_low", v_s4, 1'b0);
    chk("long_mx_low", v_mx, 1'b0);
    #1;
    rst_n = 1'b1;

    // Randomized rst_n activity; changes land 2..8 ns after a rising edge.
    cyc = 0;
    while (cyc < 9000) begin
      hi = $urandom_range(0, 14);
      repeat (hi) @(posedge clk);
      @(posedge clk);
      cyc += hi + 1;
      #($urandom_range(2, 4));
      if ($urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        #($urandom_range(1, 3));
        rst_n = 1'b1;
      end else begin
        rst_n = 1'b0;
        lo = $urandom_range(1, 3);
        repeat (lo) @(posedge clk);
        cyc += lo;
        #($urandom_range(2, 8));
        rst_n = 1'b1;
      end
    end

    // Steady state: once released long enough, every configuration is valid.
    repeat (12) @(posedge clk);
    #1;
    chk("steady_s2", v_s2, 1'b1);
    chk("steady_h3", v_h3, 1'b1);
    chk("steady_s4", v_s4, 1'b1);
    chk("steady_mx", v_mx, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
